// File: rtl/ramulator_req_tracker.sv
// Outstanding-request tracker placed in front of ramulator_sv_wrapper: allocates entries, issues, matches responses.
// Optional statistics counters are compiled in with `define RAMTRK_STATS_EN.
module ramulator_req_tracker #(
    parameter int MAX_INFLIGHT = 64,
    parameter int ADDR_W       = 64,
    parameter int SRC_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cli_req_valid,
    output logic                              cli_req_ready,
    input  logic [ADDR_W-1:0]                 cli_req_addr,
    input  logic                              cli_req_type,
    input  logic [SRC_W-1:0]                  cli_req_source_id,
    output logic                              cli_resp_valid,
    output logic [ADDR_W-1:0]                 cli_resp_addr,
    output logic                              cli_resp_type,
    output logic [SRC_W-1:0]                  cli_resp_source_id,
    output logic [31:0]                       cli_resp_latency,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic                              mem_req_type,
    output logic [SRC_W-1:0]                  mem_req_source_id,
    input  logic                              mem_resp_valid,
    input  logic [ADDR_W-1:0]                 mem_resp_addr,
    input  logic                              mem_init_done,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight_cnt,
    output logic                              unmatched_err
`ifdef RAMTRK_STATS_EN
    ,
    output logic [31:0]                       stat_accepted,
    output logic [31:0]                       stat_completed,
    output logic [31:0]                       stat_unmatched,
    output logic [31:0]                       stat_max_inflight,
    output logic [31:0]                       stat_lat_max
`endif
);

    localparam int IDX_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MAX_INFLIGHT-1:0] ent_valid;
    logic [MAX_INFLIGHT-1:0] ent_issued;
    logic [MAX_INFLIGHT-1:0] ent_type;
    logic [ADDR_W-1:0]       ent_addr [MAX_INFLIGHT];
    logic [SRC_W-1:0]        ent_src  [MAX_INFLIGHT];
    logic [31:0]             ent_ts   [MAX_INFLIGHT];

    logic [31:0]      cycle_cnt;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_found;
    logic             resp_active;
    logic             match;
    logic             miss;
    logic             cli_accept;
    logic             mem_accept;
    logic             drained;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      resp_latency;

    // Lowest-index free entry; uses registered valid bits so an entry freed this cycle is not reused yet.
    always_comb begin
        free_idx = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Only issued entries may match; an entry issued on this very edge is not yet a candidate.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (ent_issued[i] && (ent_addr[i] == mem_resp_addr)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    assign resp_active   = mem_resp_valid && (state != S_INIT);
    assign match         = resp_active && hit_found;
    assign miss          = resp_active && !hit_found;
    assign mem_accept    = mem_req_valid && mem_req_ready;
    assign cli_req_ready = (state == S_RUN) && (inflight_cnt < CNT_W'(MAX_INFLIGHT)) &&
                           (!mem_req_valid || mem_req_ready);
    assign cli_accept    = cli_req_valid && cli_req_ready;
    assign drained       = (state == S_DRAIN) && (inflight_cnt == '0) && !mem_req_valid;
    assign flush_done    = drained;
    assign resp_latency  = cycle_cnt - ent_ts[hit_idx];
    assign mem_req_source_id = SRC_W'(req_idx);

    always_comb begin
        cnt_nxt = inflight_cnt;
        if (cli_accept && !match) begin
            cnt_nxt = inflight_cnt + CNT_W'(1);
        end else if (match && !cli_accept) begin
            cnt_nxt = inflight_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (mem_init_done) state_nxt = S_RUN;
            S_RUN:   if (flush_req)     state_nxt = S_DRAIN;
            S_DRAIN: if (drained)       state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Control: entry bookkeeping, issue handshake, counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid     <= '0;
            ent_issued    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_type  <= 1'b0;
            req_idx       <= '0;
            inflight_cnt  <= '0;
            unmatched_err <= 1'b0;
            cycle_cnt     <= '0;
            cli_resp_valid <= 1'b0;
        end else begin
            cycle_cnt      <= cycle_cnt + 32'd1;
            inflight_cnt   <= cnt_nxt;
            cli_resp_valid <= match;
            if (miss) begin
                unmatched_err <= 1'b1;
            end
            if (mem_accept) begin
                ent_issued[req_idx] <= 1'b1;
            end
            if (match) begin
                ent_valid[hit_idx]  <= 1'b0;
                ent_issued[hit_idx] <= 1'b0;
            end
            if (cli_accept) begin
                ent_valid[free_idx] <= 1'b1;
                mem_req_valid       <= 1'b1;
                mem_req_addr        <= cli_req_addr;
                mem_req_type        <= cli_req_type;
                req_idx             <= free_idx;
            end else if (mem_accept) begin
                mem_req_valid <= 1'b0;
            end
        end
    end

    // Completion payload; cleared on reset so every output starts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cli_resp_addr      <= '0;
            cli_resp_type      <= 1'b0;
            cli_resp_source_id <= '0;
            cli_resp_latency   <= '0;
        end else if (match) begin
            cli_resp_addr      <= ent_addr[hit_idx];
            cli_resp_type      <= ent_type[hit_idx];
            cli_resp_source_id <= ent_src[hit_idx];
            cli_resp_latency   <= resp_latency;
        end
    end

    always_ff @(posedge clk) begin
        if (cli_accept) begin
            ent_addr[free_idx] <= cli_req_addr;
            ent_type[free_idx] <= cli_req_type;
            ent_src[free_idx]  <= cli_req_source_id;
        end
        if (mem_accept) begin
            ent_ts[req_idx] <= cycle_cnt;
        end
    end

`ifdef RAMTRK_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepted     <= '0;
            stat_completed    <= '0;
            stat_unmatched    <= '0;
            stat_max_inflight <= '0;
            stat_lat_max      <= '0;
        end else begin
            if (cli_accept) stat_accepted  <= sat_inc(stat_accepted);
            if (match)      stat_completed <= sat_inc(stat_completed);
            if (miss)       stat_unmatched <= sat_inc(stat_unmatched);
            if (32'(cnt_nxt) > stat_max_inflight) begin
                stat_max_inflight <= 32'(cnt_nxt);
            end
            if (match && (resp_latency > stat_lat_max)) begin
                stat_lat_max <= resp_latency;
            end
        end
    end
`endif

endmodule

// File: doc/ramulator_req_tracker.md
Name: ramulator_req_tracker

Overview:
- Outstanding-request tracker directly upstream of ramulator_sv_wrapper.
- Accepts client memory requests and allocates a tracking entry for each, then forwards them to the wrapper's req_* port.
- Matches the wrapper's untagged resp_addr back to the issuing entry and returns the source id, type and measured latency to the client.
- Enforces the in-flight window and provides a flush/drain handshake.

Parameters:
- MAX_INFLIGHT, 64: number of tracking entries; power of two, 2..256.
- ADDR_W, 64: address width.
- SRC_W, 32: source-id width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cli_req_valid  in  1  client request valid.
- cli_req_ready  out  1  client request accepted when valid&&ready.
- cli_req_addr  in  ADDR_W  request address.
- cli_req_type  in  1  0=read, 1=write.
- cli_req_source_id  in  SRC_W  client tag.
- cli_resp_valid  out  1  completion pulse; no backpressure.
- cli_resp_addr  out  ADDR_W  completed address.
- cli_resp_type  out  1  completed request type.
- cli_resp_source_id  out  SRC_W  tag of the completed request.
- cli_resp_latency  out  32  cycles from memory issue to response.
- mem_req_valid  out  1  to wrapper req_valid.
- mem_req_ready  in  1  from wrapper req_ready.
- mem_req_addr  out  ADDR_W  to wrapper req_addr.
- mem_req_type  out  1  to wrapper req_type.
- mem_req_source_id  out  SRC_W  entry index, zero-extended.
- mem_resp_valid  in  1  from wrapper resp_valid.
- mem_resp_addr  in  ADDR_W  from wrapper resp_addr.
- mem_init_done  in  1  from wrapper init_done.
- flush_req  in  1  level; stop accepting and drain.
- flush_done  out  1  one-cycle pulse when drained.
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  allocated entries.
- unmatched_err  out  1  sticky; a response matched no entry.

Behaviour:
- Reset state:
  - All outputs 0.
  - Every entry invalid, state S_INIT, cycle counter 0.
  - Reset mid-operation discards all outstanding entries.
- FSM:
  - S_INIT -> S_RUN when mem_init_done=1.
  - S_RUN -> S_DRAIN when flush_req=1.
  - S_DRAIN -> S_RUN when inflight_cnt==0 and no mem request is pending; flush_done=1 on that transition cycle.
  - If flush_req is still high in S_RUN, the FSM re-enters S_DRAIN on the next cycle; a second flush_done requires inflight_cnt==0 again.
  - In S_INIT, mem_resp_valid is ignored and not flagged.
- cli_req_ready (combinational) = (state==S_RUN) && (inflight_cnt<MAX_INFLIGHT) && (!mem_req_valid || mem_req_ready).
- On client accept:
  - Allocate the lowest-index free entry and store addr, type, source_id.
  - Register mem_req_* on the next edge: mem_req_valid=1, mem_req_source_id=entry index.
- mem_req_* hold stable while mem_req_valid && !mem_req_ready.
- On mem accept: mark the entry issued and store the 32-bit cycle counter as its timestamp.
- Only issued entries are match candidates.
- On mem_resp_valid:
  - Compare mem_resp_addr with all issued entries; free the lowest-index match.
  - Next cycle: cli_resp_valid=1 with the entry's addr/type/source_id and latency = counter − timestamp, mod 2^32.
  - Response latency is exactly 1 cycle.
  - No match: set unmatched_err (cleared only by rst); cli_resp_valid stays 0.
- Simultaneous allocate and free in one cycle:
  - Both take effect and inflight_cnt is unchanged.
  - The freed entry is not reallocatable until the following cycle.
- A response in the same cycle as that entry's mem accept does not match; it is flagged unmatched.
- inflight_cnt counts allocated entries, whether issued or not, and never exceeds MAX_INFLIGHT.
- Cycle counter increments every cycle from reset and wraps modulo 2^32.

Optional Feature:
- Macro RAMTRK_STATS_EN.
- When defined, adds 32-bit output ports, all reset to 0 and saturating at 0xFFFFFFFF:
  - stat_accepted: client accepts.
  - stat_completed: matched responses.
  - stat_unmatched: unmatched responses.
  - stat_max_inflight: high-water mark of inflight_cnt.
  - stat_lat_max: maximum cli_resp_latency.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset held, mem_init_done=0, cli_req_valid=1 → cli_req_ready=0 and mem_req_valid=0. Raise init_done → ready=1 the next cycle.
- One read at addr 0x40, source 7; wrapper ready immediately; response 20 cycles after issue → cli_resp_valid one cycle after mem_resp_valid, source_id=7, type=0, latency=20, inflight_cnt back to 0.
- 128 requests at stride 0x40, every 4th a write, MAX_INFLIGHT=64, responses withheld → cli_req_ready drops once inflight_cnt=64. Release responses out of order → all 128 source ids returned exactly once, unmatched_err=0.
- mem_req_ready held low 5 cycles → mem_req_addr/type/source_id stable for all 5 cycles, cli_req_ready=0, exactly one issue.
- 10 requests outstanding, assert flush_req → cli_req_ready=0. Complete all 10 → single flush_done pulse, state S_RUN. Drop flush_req → accepts resume.
- mem_resp_addr=0xDEAD00 with no matching entry → unmatched_err=1 and stays 1; no cli_resp_valid. Assert rst mid-traffic → inflight_cnt=0, unmatched_err=0, state S_INIT.
